serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 106 ++++++++++
 tb/tb_serial_adder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, LSB first, WIDTH cycles per add.
// Define SERIAL_ADDER_SUB_EN to add the sub port (a - b via ~b and carry-in 1).
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_c;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_ovf;

  logic [WIDTH-1:0] w_b_ld;
  logic             w_c_ld;
  logic             w_s;
  logic             w_co;
  logic             w_last;

`ifdef SERIAL_ADDER_SUB_EN
  always_comb begin
    w_b_ld = sub ? ~b : b;
    w_c_ld = sub ? 1'b1 : cin;
  end
`else
  always_comb begin
    w_b_ld = b;
    w_c_ld = cin;
  end
`endif

  assign w_s    = r_a[0] ^ r_b[0] ^ r_c;
  assign w_co   = (r_a[0] & r_b[0])
                | (r_c & (r_a[0] ^ r_b[0]));
  assign w_last = (r_cnt == CW'(WIDTH - 1));

  // r_a doubles as the result shifter: sum bits enter at the MSB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= 1'b0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= w_b_ld;
            r_c     <= w_c_ld;
            r_cnt   <= '0;
            r_state <= S_ADD;
          end
        end
        S_ADD: begin
          r_a   <= {w_s, r_a[WIDTH-1:1]};
          r_b   <= {1'b0, r_b[WIDTH-1:1]};
          r_c   <= w_co;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_state <= S_DONE;
            r_sum   <= {w_s, r_a[WIDTH-1:1]};
            r_carry <= w_co;
            r_ovf   <= r_c ^ w_co;
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy     = (r_state == S_ADD);
  assign done     = (r_state == S_DONE);
  assign sum      = r_sum;
  assign carry    = r_carry;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8) with a result scoreboard.
// Sub-mode steps run only when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry;
  logic         overflow;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  serial_adder #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .cin      (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub      (sub),
`endif
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .carry    (carry),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] xa,
                                 input logic [W-1:0] xb,
                                 input logic xc,
                                 input logic xs);
    logic [W-1:0] bb;
    logic         cc;
    logic [W:0]   full;
    exp_t         e;
    bb   = xs ? ~xb : xb;
    cc   = xs ? 1'b1 : xc;
    full = {1'b0, xa} + {1'b0, bb} + {{W{1'b0}}, cc};
    e.s  = full[W-1:0];
    e.c  = full[W];
    e.v  = (xa[W-1] == bb[W-1]) && (full[W-1] != xa[W-1]);
    return e;
  endfunction

  task automatic check(input string name,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic pop_cmp(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      check({tag, "_queue_empty"}, 64'd1, 64'd0);
    end else begin
      e = q.pop_front();
      check({tag, "_sum"}, 64'(sum), 64'(e.s));
      check({tag, "_carry"}, 64'(carry), 64'(e.c));
      check({tag, "_ovf"}, 64'(overflow), 64'(e.v));
    end
  endtask

  // Caller guarantees the DUT is idle at the next rising edge.
  task automatic do_op(input string tag,
                       input logic [W-1:0] xa,
                       input logic [W-1:0] xb,
                       input logic xc,
                       input logic xs);
    int k;
    int nbusy;
    logic [W-1:0] held;
    a = xa; b = xb; cin = xc; sub = xs; start = 1'b1;
    @(posedge clk);
    q.push_back(model(xa, xb, xc, xs));
    #1;
    start = 1'b0;
    a = ~xa; b = xb ^ 8'h5A; cin = ~xc; sub = ~xs;
    nbusy = 0;
    k = 0;
    while (k < 20) begin
      @(negedge clk);
      k++;
      if (busy) nbusy++;
      if (done) break;
    end
    check({tag, "_latency"}, 64'(k), 64'd9);
    check({tag, "_busy_cycles"}, 64'(nbusy), 64'd8);
    pop_cmp(tag);
    held = sum;
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    check({tag, "_hold"}, 64'(sum), 64'(held));
  endtask

  initial begin
    int nd;
    int p;
    rst_n = 1'b0;
    start = 1'b1;
    a = 8'hFF; b = 8'h01; cin = 1'b0; sub = 1'b0;
    #2;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_carry", 64'(carry), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("ff_01", 8'hFF, 8'h01, 1'b0, 1'b0);
    do_op("7f_01", 8'h7F, 8'h01, 1'b0, 1'b0);
    do_op("80_80_c", 8'h80, 8'h80, 1'b1, 1'b0);
    do_op("00_00", 8'h00, 8'h00, 1'b0, 1'b0);
    do_op("ff_ff_c", 8'hFF, 8'hFF, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++)
      do_op("rand", 8'($urandom), 8'($urandom),
            1'($urandom_range(0, 1)), 1'b0);

    // start held high with operands changing every cycle
    start = 1'b1;
    a = 8'($urandom); b = 8'($urandom);
    cin = 1'($urandom_range(0, 1));
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      if (i % 10 == 0) q.push_back(model(a, b, cin, 1'b0));
      #1;
      a = 8'($urandom); b = 8'($urandom);
      cin = 1'($urandom_range(0, 1));
      if (i == 29) start = 1'b0;
      @(negedge clk);
      p = i % 10;
      check("held_busy", 64'(busy), 64'(p <= 7));
      check("held_done", 64'(done), 64'(p == 8));
      if (p == 8) pop_cmp("held");
    end

    // reset in the middle of AA+55
    @(negedge clk);
    a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_sum", 64'(sum), 64'd0);
    check("abort_carry", 64'(carry), 64'd0);
    check("abort_ovf", 64'(overflow), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    check("abort_no_activity", 64'(nd), 64'd0);
    check("abort_sum_after", 64'(sum), 64'd0);
    do_op("aa_55", 8'hAA, 8'h55, 1'b0, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
    do_op("sub_05_07", 8'h05, 8'h07, 1'b1, 1'b1);
    do_op("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1);
    do_op("sub_rand", 8'($urandom), 8'($urandom), 1'b0, 1'b1);
`endif

    check("queue_drained", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
